// File: rtl/pc_update.sv
// Program-counter stage: holds the architectural PC, issues fetch
// requests to the IFU and advances on each instruction commit.
module pc_update #(
   parameter int unsigned         XLEN     = 32,
   parameter logic [XLEN-1:0]     RESET_PC = 32'h8000_0000,
   parameter int unsigned         CNT_W    = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             PCAsrc,
   input  logic             PCBsrc,
   input  logic [XLEN-1:0]  imm,
   input  logic [XLEN-1:0]  rs1_data,
   input  logic             commit_valid,
   input  logic             trap_valid,
   input  logic [XLEN-1:0]  trap_target,
   input  logic             halt_req,
   output logic             ifu_req_valid,
   input  logic             ifu_req_ready,
   output logic [XLEN-1:0]  pc,
   output logic             misalign_exc,
   output logic             halted,
   output logic [CNT_W-1:0] retire_cnt
);

   typedef enum logic [1:0] {
      BOOT,
      FETCH,
      EXEC,
      HALT
   } state_t;

   localparam logic [XLEN-1:0]  FOUR = XLEN'(4);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   state_t          state;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] npc;
   logic            npc_bad;

   // jalr clears bit 0 before the alignment check
   always_comb begin
      op_a    = PCAsrc ? imm : FOUR;
      op_b    = PCBsrc ? rs1_data : pc;
      sum     = op_a + op_b;
      npc     = {sum[XLEN-1:1], sum[0] & ~PCBsrc};
      npc_bad = |npc[1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= BOOT;
         pc            <= RESET_PC;
         ifu_req_valid <= 1'b0;
         misalign_exc  <= 1'b0;
         halted        <= 1'b0;
         retire_cnt    <= '0;
      end else begin
         misalign_exc <= 1'b0;
         unique case (state)
            BOOT: begin
               state         <= FETCH;
               ifu_req_valid <= 1'b1;
            end
            FETCH: begin
               if (ifu_req_ready) begin
                  state         <= EXEC;
                  ifu_req_valid <= 1'b0;
               end
            end
            EXEC: begin
               if (commit_valid) begin
                  retire_cnt <= retire_cnt + ONE;
                  if (trap_valid) begin
                     pc            <= trap_target;
                     state         <= FETCH;
                     ifu_req_valid <= 1'b1;
                  end else if (halt_req) begin
                     halted <= 1'b1;
                     state  <= HALT;
                  end else if (npc_bad) begin
                     misalign_exc <= 1'b1;
                     halted       <= 1'b1;
                     state        <= HALT;
                  end else begin
                     pc            <= npc;
                     state         <= FETCH;
                     ifu_req_valid <= 1'b1;
                  end
               end
            end
            HALT: begin
               halted        <= 1'b1;
               ifu_req_valid <= 1'b0;
            end
            default: begin
               state         <= BOOT;
               ifu_req_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_update.sv
// Directed bench for pc_update: table of commit vectors plus
// hand-written reset, stall, halt and post-halt sequences.
module tb_pc_update;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        PCAsrc;
   logic        PCBsrc;
   logic [31:0] imm;
   logic [31:0] rs1_data;
   logic        commit_valid;
   logic        trap_valid;
   logic [31:0] trap_target;
   logic        halt_req;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic [31:0] pc;
   logic        misalign_exc;
   logic        halted;
   logic [63:0] retire_cnt;

   int tests = 0;
   int fails = 0;

   pc_update dut (
      .clk(clk),
      .rst_n(rst_n),
      .PCAsrc(PCAsrc),
      .PCBsrc(PCBsrc),
      .imm(imm),
      .rs1_data(rs1_data),
      .commit_valid(commit_valid),
      .trap_valid(trap_valid),
      .trap_target(trap_target),
      .halt_req(halt_req),
      .ifu_req_valid(ifu_req_valid),
      .ifu_req_ready(ifu_req_ready),
      .pc(pc),
      .misalign_exc(misalign_exc),
      .halted(halted),
      .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        a;
      logic        b;
      logic [31:0] imm;
      logic [31:0] rs1;
      logic        trap;
      logic [31:0] tt;
      logic        halt;
      logic [31:0] epc;
      logic        ehalt;
      logic        emis;
      logic [63:0] ecnt;
   } vec_t;

   vec_t v [9];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic handshake();
      ifu_req_ready = 1'b1;
      step();
      ifu_req_ready = 1'b0;
      chk("hs_valid_drop", {63'd0, ifu_req_valid}, 64'd0);
   endtask

   task automatic commit(input logic a, input logic b,
                         input logic [31:0] im, input logic [31:0] r1,
                         input logic tr, input logic [31:0] tt,
                         input logic hl);
      PCAsrc       = a;
      PCBsrc       = b;
      imm          = im;
      rs1_data     = r1;
      trap_valid   = tr;
      trap_target  = tt;
      halt_req     = hl;
      commit_valid = 1'b1;
      step();
      commit_valid = 1'b0;
      trap_valid   = 1'b0;
      halt_req     = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n         = 1'b0;
      PCAsrc        = 1'b0;
      PCBsrc        = 1'b0;
      imm           = '0;
      rs1_data      = '0;
      commit_valid  = 1'b0;
      trap_valid    = 1'b0;
      trap_target   = '0;
      halt_req      = 1'b0;
      ifu_req_ready = 1'b0;

      v[0] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0,
               32'h8000_0004, 1'b0, 1'b0, 64'd1};
      v[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0,
               32'h8000_0008, 1'b0, 1'b0, 64'd2};
      v[2] = '{1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 1'b0, 32'h0, 1'b0,
               32'h8000_0000, 1'b0, 1'b0, 64'd3};
      v[3] = '{1'b1, 1'b1, 32'h0, 32'h8000_1001, 1'b0, 32'h0, 1'b0,
               32'h8000_1000, 1'b0, 1'b0, 64'd4};
      v[4] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h8000_0100, 1'b1,
               32'h8000_0100, 1'b0, 1'b0, 64'd5};
      v[5] = '{1'b1, 1'b1, 32'h4, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b0,
               32'hFFFF_FFFC, 1'b0, 1'b0, 64'd6};
      v[6] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0,
               32'h0000_0000, 1'b0, 1'b0, 64'd7};
      v[7] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 1'b0,
               32'h8000_0000, 1'b0, 1'b0, 64'd8};
      v[8] = '{1'b1, 1'b1, 32'h0, 32'h8000_1002, 1'b0, 32'h0, 1'b0,
               32'h8000_0000, 1'b1, 1'b1, 64'd9};

      step();
      step();
      rst_n = 1'b1;
      chk("rst_pc", {32'd0, pc}, 64'h8000_0000);
      chk("rst_valid", {63'd0, ifu_req_valid}, 64'd0);
      chk("rst_cnt", retire_cnt, 64'd0);
      chk("rst_halted", {63'd0, halted}, 64'd0);
      step();
      chk("boot_valid", {63'd0, ifu_req_valid}, 64'd1);

      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_valid", {63'd0, ifu_req_valid}, 64'd1);
         chk("stall_pc", {32'd0, pc}, 64'h8000_0000);
      end

      commit(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("fetch_commit_pc", {32'd0, pc}, 64'h8000_0000);
      chk("fetch_commit_cnt", retire_cnt, 64'd0);

      handshake();
      for (int i = 0; i < 9; i++) begin
         if (i != 0) handshake();
         commit(v[i].a, v[i].b, v[i].imm, v[i].rs1, v[i].trap, v[i].tt,
                v[i].halt);
         chk($sformatf("v%0d_pc", i), {32'd0, pc}, {32'd0, v[i].epc});
         chk($sformatf("v%0d_halted", i), {63'd0, halted},
             {63'd0, v[i].ehalt});
         chk($sformatf("v%0d_mis", i), {63'd0, misalign_exc},
             {63'd0, v[i].emis});
         chk($sformatf("v%0d_cnt", i), retire_cnt, v[i].ecnt);
         chk($sformatf("v%0d_valid", i), {63'd0, ifu_req_valid},
             {63'd0, ~v[i].ehalt});
      end

      step();
      chk("mis_pulse_end", {63'd0, misalign_exc}, 64'd0);
      chk("halt_sticky", {63'd0, halted}, 64'd1);
      ifu_req_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         commit(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1234_5670, 1'b0);
         chk("halt_valid", {63'd0, ifu_req_valid}, 64'd0);
         chk("halt_pc", {32'd0, pc}, 64'h8000_0000);
         chk("halt_cnt", retire_cnt, 64'd9);
      end
      ifu_req_ready = 1'b0;

      do_reset();
      chk("rst2_halted", {63'd0, halted}, 64'd0);
      chk("rst2_cnt", retire_cnt, 64'd0);
      step();
      handshake();
      commit(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("ebreak_pc", {32'd0, pc}, 64'h8000_0000);
      chk("ebreak_halted", {63'd0, halted}, 64'd1);
      chk("ebreak_mis", {63'd0, misalign_exc}, 64'd0);
      chk("ebreak_cnt", retire_cnt, 64'd1);
      chk("ebreak_valid", {63'd0, ifu_req_valid}, 64'd0);

      do_reset();
      step();
      handshake();
      commit(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("pre_abort_pc", {32'd0, pc}, 64'h8000_0020);
      step();
      chk("pre_abort_valid", {63'd0, ifu_req_valid}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_valid", {63'd0, ifu_req_valid}, 64'd0);
      chk("abort_pc", {32'd0, pc}, 64'h8000_0000);
      chk("abort_cnt", retire_cnt, 64'd0);
      step();
      rst_n = 1'b1;
      chk("abort_boot_valid", {63'd0, ifu_req_valid}, 64'd0);
      step();
      chk("abort_fetch_valid", {63'd0, ifu_req_valid}, 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
